// File: rtl/rgb2hsl_pkg.sv
// Shared types and default sizing for the RGB-to-HSL frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgb2hsl_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int LAT_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/valid_pipe.sv
// DEPTH-stage valid shift register tracking pixels in flight through the converter.
// Latency: DEPTH enabled cycles from d to q.
// Backpressure: ce=0 freezes every stage, so no token is lost or duplicated.
module valid_pipe #(
  parameter int DEPTH = 8
) (
  input  logic Clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  // Shift one stage per enabled cycle, clear on reset.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (ce) begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/rgb2hsl_frame_ctrl.sv
// Frame sequencer: issues pixel reads, tracks them through the converter and numbers results.
// Latency: first read the cycle after start; each result LAT enabled cycles after its read.
// Backpressure: out_ready low with out_valid high drops cvt_ce, freezing reads and pipe.
// Optional RGB2HSL_CTRL_PERF_EN adds busy-cycle and stall-cycle counters.
module rgb2hsl_frame_ctrl
  import rgb2hsl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LAT    = LAT_DEF
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pix,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              cvt_ce,
  output logic              out_valid,
  output logic [ADDR_W-1:0] wr_addr
`ifdef RGB2HSL_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] num_pix_q;
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] retired;
  logic              accept;
  logic              xfer;

  // A stalled result at the sink holds the whole pipe, including the memory read.
  assign cvt_ce = ~(out_valid & ~out_ready);
  assign accept = (state == IDLE) & start;
  assign xfer   = out_valid & out_ready;
  assign rd_en  = (state == RUN) & cvt_ce & (issued < num_pix_q);

  assign rd_addr = issued;
  assign wr_addr = retired;
  assign busy    = (state == RUN) | (state == DRAIN);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave RUN on the last read, leave DRAIN on the last transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_pix == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en && (issued == num_pix_q - ONE)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && (retired == num_pix_q - ONE)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame length capture and issue/retire counters; start restarts both at zero.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      num_pix_q <= '0;
      issued    <= '0;
      retired   <= '0;
    end else if (accept) begin
      num_pix_q <= num_pix;
      issued    <= '0;
      retired   <= '0;
    end else begin
      if (rd_en) begin
        issued <= issued + ONE;
      end
      if (xfer) begin
        retired <= retired + ONE;
      end
    end
  end

  valid_pipe #(
    .DEPTH (LAT)
  ) u_valid_pipe (
    .Clk (Clk),
    .rst (rst),
    .ce  (cvt_ce),
    .d   (rd_en),
    .q   (out_valid)
  );

`ifdef RGB2HSL_CTRL_PERF_EN
  // Saturating busy/stall counters, cleared on accepted start and held between frames.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (busy) begin
      if (perf_cycles != '1) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (!cvt_ce && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgb2hsl_frame_ctrl.sv
// Randomized self-checking bench for rgb2hsl_frame_ctrl.
// Latency: n/a.
// Backpressure: out_ready driven fixed, scripted or random per frame.
module tb_rgb2hsl_frame_ctrl;

  localparam int AW  = 20;
  localparam int LAT = 8;

  logic          Clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_pix;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          cvt_ce;
  logic          out_valid;
  logic [AW-1:0] wr_addr;
`ifdef RGB2HSL_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stalls;
`endif

  rgb2hsl_frame_ctrl #(
    .ADDR_W (AW),
    .LAT    (LAT)
  ) dut (
    .Clk       (Clk),
    .rst       (rst),
    .start     (start),
    .num_pix   (num_pix),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cvt_ce    (cvt_ce),
    .out_valid (out_valid),
    .wr_addr   (wr_addr)
`ifdef RGB2HSL_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state, owned by the monitor below.
  int cyc = 0;
  int en_cnt, rd_next, wr_next, reads, xfers, dones, busy_cyc, stalls;
  int err_rd, err_wr, err_v, err_ce;
  int start_cyc, first_rd, first_v, last_x, done_cyc;
  int iq[$];
  int clr_seen = 0;
  int clr_tog  = 0;
  bit m_ce, m_v;

  // Model: every read is a token due LAT enabled cycles later; results leave in issue order.
  always @(negedge Clk) begin
    cyc++;
    if (rst || (clr_tog != clr_seen)) begin
      clr_seen = clr_tog;
      en_cnt = 0; rd_next = 0; wr_next = 0; reads = 0; xfers = 0; dones = 0;
      busy_cyc = 0; stalls = 0; err_rd = 0; err_wr = 0; err_v = 0; err_ce = 0;
      start_cyc = -1; first_rd = -1; first_v = -1; last_x = -1; done_cyc = -1;
      iq.delete();
    end
    if (!rst) begin
      m_ce = !(out_valid && !out_ready);
      if (cvt_ce !== m_ce) err_ce++;
      m_v = (iq.size() > 0) && (en_cnt >= iq[0] + LAT);
      if (out_valid !== m_v) err_v++;
      if (start && start_cyc < 0) start_cyc = cyc;
      if (busy === 1'b1) busy_cyc++;
      if (!m_ce) stalls++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (wr_addr != AW'(wr_next)) err_wr++;
        wr_next++;
        if (iq.size() > 0) void'(iq.pop_front());
        xfers++;
        last_x = cyc;
      end
      if (rd_en) begin
        if (!m_ce) err_rd++;
        if (rd_addr != AW'(rd_next)) err_rd++;
        rd_next++;
        iq.push_back(en_cnt);
        reads++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_ce) en_cnt++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  // rmode: 0 ready always, 1 random ready, 2 ready low for 3 cycles while a result waits.
  task automatic run_frame(input int n, input int rmode, input int inj, input int alt,
                           input string tag);
    int to;
    clr_tog++;
    num_pix   = AW'(n);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    to = 1;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        to = 0;
        break;
      end
      start = (i == inj);
      if (i == inj) num_pix = AW'(alt);
      case (rmode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !((i >= LAT + 2) && (i < LAT + 5));
        default: out_ready = 1'b1;
      endcase
      @(posedge Clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_timeout"}, to, 0);
  endtask

  task automatic frame_checks(input string tag, input int n);
    chk({tag, "_reads"}, reads, n);
    chk({tag, "_xfers"}, xfers, n);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_rd_seq"}, err_rd, 0);
    chk({tag, "_wr_seq"}, err_wr, 0);
    chk({tag, "_valid"}, err_v, 0);
    chk({tag, "_ce"}, err_ce, 0);
  endtask

  initial begin
    int to;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    num_pix   = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_cvt_ce", cvt_ce, 1);
    repeat (2) @(posedge Clk);
    #1;
    rst = 1'b0;
    @(posedge Clk); #1;

    // Small frame, no backpressure: exact timing.
    run_frame(4, 0, -1, 0, "f4");
    frame_checks("f4", 4);
    chk("f4_first_rd", first_rd - start_cyc, 1);
    chk("f4_first_valid", first_v - start_cyc, 1 + LAT);
    chk("f4_done_after_xfer", done_cyc - last_x, 1);

    // Back-to-back frame with a 3-cycle sink stall.
    run_frame(16, 2, -1, 0, "f16");
    frame_checks("f16", 16);
    chk("f16_stalls", stalls, 3);
    chk("f16_busy_cycles", busy_cyc, 16 + LAT + 3);
    chk("f16_done_cyc", done_cyc - start_cyc, 16 + LAT + 4);
`ifdef RGB2HSL_CTRL_PERF_EN
    chk("f16_perf_cycles", perf_cycles, 16 + LAT + 3);
    chk("f16_perf_stalls", perf_stalls, 3);
`endif

    // Empty frame.
    run_frame(0, 0, -1, 0, "f0");
    chk("f0_reads", reads, 0);
    chk("f0_xfers", xfers, 0);
    chk("f0_dones", dones, 1);
    chk("f0_busy", busy_cyc, 0);
    chk("f0_done_cyc", done_cyc - start_cyc, 1);

    // Start pulse in mid-frame must be ignored.
    run_frame(12, 1, 3, 5, "finj");
    frame_checks("finj", 12);

    // Reset in the middle of a 10-pixel frame.
    clr_tog++;
    num_pix = AW'(10);
    start   = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    to = 1;
    for (int i = 0; i < 100; i++) begin
      if (reads >= 5) begin
        to = 0;
        break;
      end
      @(posedge Clk); #1;
    end
    chk("mid_wait_timeout", to, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_cvt_ce", cvt_ce, 1);
    clr_tog++;
    repeat (2) @(posedge Clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    chk("mid_rst_no_done", dones, 0);
    run_frame(3, 0, -1, 0, "f3");
    frame_checks("f3", 3);

    // Single-pixel frame and random frames under random backpressure.
    run_frame(1, 1, -1, 0, "f1");
    frame_checks("f1", 1);
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(2, 700);
      run_frame(n, 1, -1, 0, "frnd");
      frame_checks("frnd", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
